// File: rtl/spc_pkg.sv
// Shared definitions for the SPC serial register block: FSM encoding and
// default command codes.
package spc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_WDATA   = 3'd2,
      ST_RDATA   = 3'd3,
      ST_DISCARD = 3'd4
   } spc_state_e;

   localparam logic [7:0] SPC_CMD_WRITE = 8'h91;
   localparam logic [7:0] SPC_CMD_READ  = 8'h92;

   // Counter must hold every legal bit count plus one saturated "too long" value.
   function automatic int spc_cnt_width(input int n_bytes);
      return $clog2(8 * (n_bytes + 1) + 2);
   endfunction

endpackage

// File: rtl/spc_shifter.sv
// LSB-first staging shift register with a saturating bit counter; both are
// cleared synchronously while the frame select is inactive.
module spc_shifter #(
   parameter int N_BYTES = 2,
   parameter int CNT_W   = 5,
   parameter int CNT_MAX = 25
) (
   input  logic                   sclk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   shift_en,
   input  logic                   count_en,
   input  logic                   bit_in,
   output logic [8*N_BYTES-1:0]   data,
   output logic [CNT_W-1:0]       count
);

   localparam int W = 8 * N_BYTES;

   // NOTE: staging is a plain register, not a memory, so it is reset along
   // with the counter; a stale partial frame can never leak into a commit.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         count <= '0;
      end else if (clear) begin
         data  <= '0;
         count <= '0;
      end else begin
         // New bits enter at the top so the first data bit ends up in bit 0.
         if (shift_en)
            data <= {bit_in, data[W-1:1]};
         if (count_en && (count != CNT_W'(CNT_MAX)))
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/spc_rw.sv
// Serial write/readback register: command byte then N_BYTES data bytes,
// LSB first, framed by cs_n and clocked entirely by sclk.
module spc_rw
   import spc_pkg::*;
#(
   parameter int                   N_BYTES     = 2,
   parameter logic [7:0]           CMD_WRITE   = SPC_CMD_WRITE,
   parameter logic [7:0]           CMD_READ    = SPC_CMD_READ,
   parameter logic [8*N_BYTES-1:0] RESET_VALUE = '0
) (
   input  logic                   sclk,
   input  logic                   rst_n,
   input  logic                   cs_n,
   input  logic                   mosi,
   output logic                   miso,
   output logic [8*N_BYTES-1:0]   out,
   output logic                   data_ready,
   output logic                   frame_err
);

   localparam int OUT_W      = 8 * N_BYTES;
   localparam int FRAME_BITS = 8 * (N_BYTES + 1);
   localparam int CNT_W      = spc_cnt_width(N_BYTES);
   localparam int CNT_MAX    = FRAME_BITS + 1;

   spc_state_e         state;
   logic [7:0]         cmd_sr;
   logic [7:0]         cmd_next;
   logic [OUT_W-1:0]   staging;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   rd_idx;
   logic               rd_bit;

   spc_shifter #(
      .N_BYTES (N_BYTES),
      .CNT_W   (CNT_W),
      .CNT_MAX (CNT_MAX)
   ) u_shifter (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .clear    (cs_n),
      .shift_en (!cs_n && (state == ST_WDATA)),
      .count_en (!cs_n),
      .bit_in   (mosi),
      .data     (staging),
      .count    (bit_cnt)
   );

   // NOTE: every always_comb output gets a default before any branch so no
   // latch can be inferred for a path that does not assign it.
   always_comb begin
      cmd_next = {mosi, cmd_sr[7:1]};
      rd_idx   = bit_cnt - CNT_W'(8);
      rd_bit   = 1'b0;
      for (int i = 0; i < OUT_W; i++)
         if (rd_idx == CNT_W'(i))
            rd_bit = out[i];
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register sees pre-edge values, independent of statement order.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cmd_sr     <= '0;
         out        <= RESET_VALUE;
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
         if (cs_n) begin
            state <= ST_IDLE;
            case (state)
               ST_WDATA: begin
                  if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                     out        <= staging;
                     data_ready <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               ST_CMD, ST_DISCARD: frame_err <= 1'b1;
               default: ;
            endcase
         end else begin
            case (state)
               ST_IDLE: begin
                  cmd_sr <= cmd_next;
                  state  <= ST_CMD;
               end
               ST_CMD: begin
                  cmd_sr <= cmd_next;
                  if (bit_cnt == CNT_W'(7)) begin
                     if (cmd_next == CMD_WRITE)
                        state <= ST_WDATA;
                     else if (cmd_next == CMD_READ)
                        state <= ST_RDATA;
                     else
                        state <= ST_DISCARD;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Readback slots are indexed by the bit counter, which already stands at
   // 8 on the falling edge that follows the last command bit.
   always_ff @(negedge sclk or negedge rst_n) begin
      if (!rst_n)
         miso <= 1'b0;
      else if ((state == ST_RDATA) && (bit_cnt >= CNT_W'(8)) &&
               (bit_cnt < CNT_W'(FRAME_BITS)))
         miso <= rd_bit;
      else
         miso <= 1'b0;
   end

endmodule

// File: tb/tb_spc_rw.sv
// Directed bench for spc_rw: write, back-to-back, bad frames, readback and
// mid-frame reset, each with hand-computed expectations.
module tb_spc_rw;

   logic        sclk;
   logic        rst_n;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic [15:0] out;
   logic        data_ready;
   logic        frame_err;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int dr_cnt   = 0;
   int fe_cnt   = 0;
   logic [15:0] dr_log[$];

   spc_rw #(.N_BYTES(2)) dut (
      .sclk       (sclk),
      .rst_n      (rst_n),
      .cs_n       (cs_n),
      .mosi       (mosi),
      .miso       (miso),
      .out        (out),
      .data_ready (data_ready),
      .frame_err  (frame_err)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   // Pulses last one rising-to-rising period, so each is seen once here.
   always @(negedge sclk) begin
      if (data_ready) begin
         dr_cnt++;
         dr_log.push_back(out);
      end
      if (frame_err)
         fe_cnt++;
   end

   // Bits go out LSB first; bits[7:0] is the command. Returns with cs_n high
   // so a following frame leaves exactly one idle rising edge.
   task automatic send_frame(input logic [63:0] bits, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         @(negedge sclk);
         cs_n = 1'b0;
         mosi = bits[i];
      end
      @(negedge sclk);
      cs_n = 1'b1;
      mosi = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge sclk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      repeat (3) @(negedge sclk);
      chk_cnt++; if (out !== 16'h0000) $display("FAIL reset_out got %h want %h", out, 16'h0000); else pass_cnt++;
      chk_cnt++; if (data_ready !== 1'b0) $display("FAIL reset_data_ready got %b want 0", data_ready); else pass_cnt++;
      chk_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else pass_cnt++;
      chk_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got %b want 0", miso); else pass_cnt++;
      rst_n = 1'b1;
      @(negedge sclk);
   endtask

   task automatic test_write_ff();
      int dr0 = dr_cnt;
      int fe0 = fe_cnt;
      send_frame({40'h0, 8'hFF, 8'hFF, 8'h91}, 24);
      settle();
      chk_cnt++; if (out !== 16'hFFFF) $display("FAIL write_ff_out got %h want %h", out, 16'hFFFF); else pass_cnt++;
      chk_cnt++; if (dr_cnt - dr0 != 1) $display("FAIL write_ff_data_ready pulses got %0d want 1", dr_cnt - dr0); else pass_cnt++;
      chk_cnt++; if (fe_cnt - fe0 != 0) $display("FAIL write_ff_frame_err pulses got %0d want 0", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int fe0 = fe_cnt;
      dr_log.delete();
      send_frame({40'h0, 8'h55, 8'h55, 8'h91}, 24);
      send_frame({40'h0, 8'h00, 8'h00, 8'h91}, 24);
      settle();
      chk_cnt++; if (dr_log.size() != 2) $display("FAIL b2b_commits got %0d want 2", dr_log.size()); else pass_cnt++;
      chk_cnt++; if (dr_log.size() < 1 || dr_log[0] !== 16'h5555) $display("FAIL b2b_first got %h want %h", (dr_log.size() > 0) ? dr_log[0] : 16'hxxxx, 16'h5555); else pass_cnt++;
      chk_cnt++; if (dr_log.size() < 2 || dr_log[1] !== 16'h0000) $display("FAIL b2b_second got %h want %h", (dr_log.size() > 1) ? dr_log[1] : 16'hxxxx, 16'h0000); else pass_cnt++;
      chk_cnt++; if (fe_cnt - fe0 != 0) $display("FAIL b2b_frame_err pulses got %0d want 0", fe_cnt - fe0); else pass_cnt++;
   endtask

   task automatic test_unknown_cmd();
      int dr0;
      int fe0;
      send_frame({40'h0, 8'h55, 8'h55, 8'h91}, 24);
      settle();
      chk_cnt++; if (out !== 16'h5555) $display("FAIL unk_setup_out got %h want %h", out, 16'h5555); else pass_cnt++;
      dr0 = dr_cnt;
      fe0 = fe_cnt;
      send_frame({40'h0, 8'hAA, 8'hAA, 8'h13}, 24);
      settle();
      chk_cnt++; if (out !== 16'h5555) $display("FAIL unk_out got %h want %h", out, 16'h5555); else pass_cnt++;
      chk_cnt++; if (fe_cnt - fe0 != 1) $display("FAIL unk_frame_err pulses got %0d want 1", fe_cnt - fe0); else pass_cnt++;
      chk_cnt++; if (dr_cnt - dr0 != 0) $display("FAIL unk_data_ready pulses got %0d want 0", dr_cnt - dr0); else pass_cnt++;
   endtask

   task automatic test_short_long();
      int dr0 = dr_cnt;
      int fe0 = fe_cnt;
      send_frame({48'h0, 8'hAA, 8'h91}, 16);
      settle();
      chk_cnt++; if (out !== 16'h5555) $display("FAIL short_out got %h want %h", out, 16'h5555); else pass_cnt++;
      chk_cnt++; if (fe_cnt - fe0 != 1) $display("FAIL short_frame_err pulses got %0d want 1", fe_cnt - fe0); else pass_cnt++;
      fe0 = fe_cnt;
      send_frame({32'h0, 8'h01, 8'hAA, 8'hAA, 8'h91}, 32);
      settle();
      chk_cnt++; if (out !== 16'h5555) $display("FAIL long_out got %h want %h", out, 16'h5555); else pass_cnt++;
      chk_cnt++; if (fe_cnt - fe0 != 1) $display("FAIL long_frame_err pulses got %0d want 1", fe_cnt - fe0); else pass_cnt++;
      chk_cnt++; if (dr_cnt - dr0 != 0) $display("FAIL short_long_data_ready pulses got %0d want 0", dr_cnt - dr0); else pass_cnt++;
   endtask

   task automatic test_read();
      logic [7:0]  cmd = 8'h92;
      logic [15:0] rx  = '0;
      int dr0;
      int fe0;
      send_frame({40'h0, 8'hA5, 8'hC3, 8'h91}, 24);
      settle();
      chk_cnt++; if (out !== 16'hA5C3) $display("FAIL read_setup_out got %h want %h", out, 16'hA5C3); else pass_cnt++;
      dr0 = dr_cnt;
      fe0 = fe_cnt;
      for (int i = 0; i < 8; i++) begin
         @(negedge sclk);
         cs_n = 1'b0;
         mosi = cmd[i];
      end
      for (int j = 0; j < 16; j++) begin
         @(negedge sclk);
         mosi = 1'b0;
         @(posedge sclk);
         #1 rx[j] = miso;
      end
      @(negedge sclk);
      @(posedge sclk);
      #1;
      chk_cnt++; if (miso !== 1'b0) $display("FAIL read_tail_miso got %b want 0", miso); else pass_cnt++;
      @(negedge sclk);
      cs_n = 1'b1;
      settle();
      chk_cnt++; if (rx !== 16'hA5C3) $display("FAIL read_miso_bits got %h want %h", rx, 16'hA5C3); else pass_cnt++;
      chk_cnt++; if (out !== 16'hA5C3) $display("FAIL read_out got %h want %h", out, 16'hA5C3); else pass_cnt++;
      chk_cnt++; if (dr_cnt - dr0 != 0 || fe_cnt - fe0 != 0) $display("FAIL read_pulses got dr=%0d fe=%0d want 0 0", dr_cnt - dr0, fe_cnt - fe0); else pass_cnt++;
      chk_cnt++; if (miso !== 1'b0) $display("FAIL read_idle_miso got %b want 0", miso); else pass_cnt++;
   endtask

   task automatic test_reset_mid_frame();
      logic [23:0] bits = {8'hFF, 8'hFF, 8'h91};
      int dr0;
      int fe0;
      for (int i = 0; i < 12; i++) begin
         @(negedge sclk);
         cs_n = 1'b0;
         mosi = bits[i];
      end
      @(negedge sclk);
      rst_n = 1'b0;
      #1;
      chk_cnt++; if (out !== 16'h0000) $display("FAIL midrst_out got %h want %h", out, 16'h0000); else pass_cnt++;
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (2) @(negedge sclk);
      rst_n = 1'b1;
      @(negedge sclk);
      dr0 = dr_cnt;
      fe0 = fe_cnt;
      send_frame({40'h0, 8'h34, 8'h12, 8'h91}, 24);
      settle();
      chk_cnt++; if (out !== 16'h3412) $display("FAIL midrst_next_out got %h want %h", out, 16'h3412); else pass_cnt++;
      chk_cnt++; if (dr_cnt - dr0 != 1) $display("FAIL midrst_data_ready pulses got %0d want 1", dr_cnt - dr0); else pass_cnt++;
      chk_cnt++; if (fe_cnt - fe0 != 0) $display("FAIL midrst_frame_err pulses got %0d want 0", fe_cnt - fe0); else pass_cnt++;
   endtask

   initial begin
      rst_n = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      test_reset();
      test_write_ff();
      test_back_to_back();
      test_unknown_cmd();
      test_short_long();
      test_read();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/spc_rw.md
SPC_RW -- requirements
Module: spc_rw

Interface
REQ-001 SHALL have parameter N_BYTES, default 2, number of data bytes per frame (1..8).
REQ-002 SHALL have parameter CMD_WRITE, default 8'h91, write command code.
REQ-003 SHALL have parameter CMD_READ, default 8'h92, readback command code.
REQ-004 SHALL have parameter RESET_VALUE, default 0, reset contents of out (8*N_BYTES bits).
REQ-005 SHALL have port sclk, input, 1, the only clock, free-running; all logic uses its edges.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port cs_n, input, 1, active-low frame select, sampled on rising sclk.
REQ-008 SHALL have port mosi, input, 1, serial data in, sampled on rising sclk.
REQ-009 SHALL have port miso, output, 1, serial readback data, changed only on falling sclk.
REQ-010 SHALL have port out, output, 8*N_BYTES, parallel register contents.
REQ-011 SHALL have port data_ready, output, 1, one-cycle pulse when out is updated.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse when a frame is discarded.

Function
REQ-013 SHALL transmit each byte LSB first, and map data byte k (k=0 first after the command) to out[8k+7:8k].
REQ-014 SHALL run FSM states IDLE, CMD, WDATA, RDATA, DISCARD; IDLE->CMD on the first rising edge with cs_n=0 (that bit is command bit 0).
REQ-015 SHALL, after 8 command bits, go to WDATA on CMD_WRITE, to RDATA on CMD_READ, and otherwise to DISCARD.
REQ-016 SHALL, in WDATA, shift the received bits into a staging register; out SHALL stay unchanged until commit.
REQ-017 SHALL commit staging to out on the first rising edge that samples cs_n=1, only if exactly 8*(N_BYTES+1) bits were received.
REQ-018 SHALL set out and pulse data_ready high for exactly one cycle on that same edge (latency: one rising edge after cs_n deasserts).
REQ-019 SHALL treat a write frame as invalid if it is short (cs_n rises early) or long (extra bits); SHALL then leave out unchanged and pulse frame_err for one cycle on the cs_n-high edge.
REQ-020 SHALL, for an unknown command, ignore all remaining bits, leave out unchanged, and pulse frame_err when cs_n rises.
REQ-021 SHALL, in RDATA, drive out bits LSB first, starting on the falling edge after the 8th command bit and ending after 8*N_BYTES bits.
REQ-022 SHALL drive miso=0 at all times outside RDATA bit slots, including after the last read bit.
REQ-023 SHALL end a read frame with no data_ready and no frame_err; an early cs_n rise in RDATA SHALL end it silently.
REQ-024 SHALL saturate the bit counter, with width clog2(8*(N_BYTES+1)+2), so that a long frame cannot wrap to a valid count.
REQ-025 SHALL return to IDLE on every rising edge that samples cs_n=1; back-to-back frames with one idle cycle SHALL be accepted.

Reset
REQ-026 SHALL, on rst_n low, immediately set out=RESET_VALUE, data_ready=0, frame_err=0, miso=0, state=IDLE, counter=0 and staging=0.
REQ-027 SHALL discard any frame in progress if reset asserts mid-frame; the first frame after rst_n rises SHALL decode normally.

Structure
REQ-028 SHALL place the FSM state encoding and the default command codes in shared package spc_pkg.
REQ-029 SHALL use one sub-module, spc_shifter: an N_BYTES-wide LSB-first shift register with a saturating bit counter and clear.

Verification
REQ-030 SHALL check: reset, then write [91|FF|FF] -> out=16'hFFFF, data_ready one pulse, frame_err never.
REQ-031 SHALL check: write [91|55|55], then one idle cycle, then [91|00|00] -> out=16'h5555, then out=16'h0000.
REQ-032 SHALL check: out=16'h5555, then [13|AA|AA] -> out stays 16'h5555, frame_err pulses once.
REQ-033 SHALL check: [91|AA] with cs_n raised after 16 bits, and [91|AA|AA|01] -> out unchanged, frame_err pulses on each.
REQ-034 SHALL check: out=16'hA5C3, then [92] followed by 16 clocks -> miso bits on rising edges form C3 then A5 LSB first; out unchanged.
REQ-035 SHALL check: rst_n low after 12 bits of a [91|FF|FF] frame -> out=0, then a full [91|12|34] frame -> out=16'h3412.
